// File: rtl/ce_src_pkg.sv
// Shared types and default parameters for the clock-enabled data source.
package ce_src_pkg;

  // Run-control states of the data source
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DIV   = 4;
  localparam int DEF_DEPTH = 2;

endpackage

// File: rtl/ce_data_source_if.sv
// Control and data bundle between the data source and whoever drives it.
interface ce_data_source_if
  import ce_src_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             Start;
  logic             Stop;
  logic             Load;
  logic [WIDTH-1:0] LdVal;
  logic             Up;
  logic [WIDTH-1:0] Dout;
  logic             Ce;
  logic             Run;
  logic             Wrap;

  modport master (
    output Start, Stop, Load, LdVal, Up,
    input  Dout, Ce, Run, Wrap
  );

  modport slave (
    input  Start, Stop, Load, LdVal, Up,
    output Dout, Ce, Run, Wrap
  );
endinterface

// File: rtl/ce_prescaler.sv
// Modulo-DIV counter producing a registered one-cycle strobe after each wrap.
// Clear has priority over enable; a disabled prescaler holds its count.
module ce_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic strobe
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;
  logic          strobe_r;
  logic          at_last_s;

  assign at_last_s = (cnt_r == LAST);
  assign strobe    = strobe_r;

  // Count phase and register the strobe for the cycle after the wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      strobe_r <= 1'b0;
    end else if (clr) begin
      cnt_r    <= '0;
      strobe_r <= 1'b0;
    end else if (en) begin
      strobe_r <= at_last_s;
      cnt_r    <= at_last_s ? '0 : cnt_r + CW'(1);
    end else begin
      strobe_r <= 1'b0;
    end
  end
endmodule

// File: rtl/ce_data_source.sv
// Periodic clock-enable and up/down data word feeding a DEPTH-stage register
// chain. A run ends with a drain of DEPTH strobes so the last word reaches the
// end of the chain before the source goes idle.
module ce_data_source
  import ce_src_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              CLK,
  input  logic              RST,
  ce_data_source_if.slave   bus
);
  localparam int DCW = $clog2(DEPTH + 1);
  localparam logic [DCW-1:0] DEPTH_V = DCW'(DEPTH);
  localparam logic [DCW-1:0] LAST_V  = DCW'(1);

  state_t           state_r;
  logic [WIDTH-1:0] dout_r;
  logic             wrap_r;
  logic             run_r;
  logic [DCW-1:0]   drain_r;

  logic             ce_s;
  logic             last_s;
  logic             clr_s;
  logic             en_s;
  logic [WIDTH-1:0] step_s;
  logic             wrapping_s;

  ce_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk    (CLK),
    .rst_n  (RST),
    .clr    (clr_s),
    .en     (en_s),
    .strobe (ce_s)
  );

  // Prescaler is held cleared while idle and on the edge that ends the drain
  always_comb begin
    last_s = 1'b0;
    if ((state_r == ST_DRAIN) && ce_s && (drain_r == LAST_V)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
    clr_s = (state_r == ST_IDLE) || last_s;
    en_s  = !clr_s;
  end

  // Next data word for an advance and whether that advance wraps
  always_comb begin
    step_s     = dout_r;
    wrapping_s = 1'b0;
    if (bus.Up) begin
      step_s     = dout_r + WIDTH'(1);
      wrapping_s = (dout_r == {WIDTH{1'b1}});
    end else begin
      step_s     = dout_r - WIDTH'(1);
      wrapping_s = (dout_r == {WIDTH{1'b0}});
    end
  end

  // Run-control FSM with data word, drain counter and wrap pulse
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_IDLE;
      dout_r  <= '0;
      wrap_r  <= 1'b0;
      run_r   <= 1'b0;
      drain_r <= '0;
    end else begin
      wrap_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.Load) begin
            dout_r <= bus.LdVal;
          end
          if (bus.Start && !bus.Stop) begin
            state_r <= ST_RUN;
            run_r   <= 1'b1;
          end
        end
        ST_RUN: begin
          // Load wins over an advance on the same edge
          if (bus.Load) begin
            dout_r <= bus.LdVal;
          end else if (ce_s) begin
            dout_r <= step_s;
            wrap_r <= wrapping_s;
          end
          if (bus.Stop) begin
            state_r <= ST_DRAIN;
            drain_r <= DEPTH_V;
          end
        end
        ST_DRAIN: begin
          if (ce_s) begin
            if (drain_r == LAST_V) begin
              state_r <= ST_IDLE;
              run_r   <= 1'b0;
              drain_r <= '0;
            end else begin
              drain_r <= drain_r - DCW'(1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          run_r   <= 1'b0;
          drain_r <= '0;
        end
      endcase
    end
  end

  assign bus.Dout = dout_r;
  assign bus.Ce   = ce_s;
  assign bus.Run  = run_r;
  assign bus.Wrap = wrap_r;
endmodule

// File: doc/ce_data_source.md
# ce_data_source

Upstream feeder for the two-stage clock-enabled 4-bit register chain. Generates a periodic single-cycle clock-enable strobe (`Ce`) and a 4-bit data word (`Dout`, wired to the chain's `Din`). The data word steps up or down by one after every strobe. A start/stop state machine controls the block, and it ends each run with a drain phase so the last value propagates through the full downstream chain.

## Interface
Parameters:
- `WIDTH`, default 4: data width; matches the downstream register chain.
- `DIV`, default 4: `Ce` period in clocks; legal range ≥ 1.
- `DEPTH`, default 2: number of downstream register stages; sets the drain strobe count; legal range ≥ 1.

Ports:
- `CLK`, in, 1: single clock; all state changes on the rising edge.
- `RST`, in, 1: asynchronous, active-low reset.
- `Start`, in, 1: level-sampled; begins a run from IDLE.
- `Stop`, in, 1: level-sampled; ends a run (RUN→DRAIN).
- `Load`, in, 1: synchronous load of `LdVal` into the data word.
- `LdVal`, in, `WIDTH`: load value.
- `Up`, in, 1: step direction; 1 = increment, 0 = decrement; sampled at each advance.
- `Dout`, out, `WIDTH`: data word to the downstream `Din`; registered.
- `Ce`, out, 1: clock-enable strobe to the downstream `Ce`; registered; one cycle wide unless `DIV` = 1.
- `Run`, out, 1: high in RUN and DRAIN.
- `Wrap`, out, 1: one-cycle registered pulse when an advance wraps.

## Operation
- **States:** IDLE, RUN, DRAIN.
- **Reset:** `RST` low forces the following immediately, regardless of clock:
  - state = IDLE, prescaler = 0, drain count = 0;
  - `Dout` = 0, `Ce` = 0, `Run` = 0, `Wrap` = 0.
- **IDLE:**
  - `Ce` = 0.
  - `Load` writes `LdVal` to `Dout`.
  - `Start`=1 and `Stop`=0 → RUN, prescaler cleared.
  - `Start` together with `Load` on the same edge: both take effect.
- **RUN:**
  - The prescaler counts 0..`DIV`-1 and wraps; `Ce` is high for the cycle following each wrap.
  - **Advance:** on every edge where `Ce` is high, `Dout` ← `Dout` ± 1 (modulo 2^`WIDTH`, direction from `Up`). The downstream stage therefore captures the old value on that same edge.
  - **Wrap:** `Wrap` is asserted for one cycle when an advance goes all-ones→0 (up) or 0→all-ones (down).
  - **Load in RUN:** `Load` overrides an advance on the same edge; `LdVal` is written and no step occurs.
  - **Stop in RUN:** `Stop`=1 → DRAIN, drain count ← `DEPTH`. The prescaler keeps running without a phase reset.
- **DRAIN:**
  - `Ce` strobes continue at the same period.
  - `Dout` is frozen; no advance, and `Load` and `Up` are ignored.
  - Each `Ce`-high edge decrements the drain count.
  - On the edge that consumes the last strobe → IDLE. `Ce` is 0 from the next cycle and the prescaler is cleared.
- **Input priority:**
  - `Start` and `Stop` together: `Stop` wins (stay in IDLE, or leave RUN).
  - `Start` is ignored in RUN and DRAIN.
  - `Stop` is ignored in IDLE and DRAIN.
- **Reset mid-run or mid-drain:** immediate return to IDLE with all outputs 0. The strobe in progress is truncated.

## Timing
- Start sampled at edge k → `Run`=1 from cycle k+1; first `Ce` high in the cycle after edge k+`DIV`; subsequent strobes every `DIV` cycles.
- `DIV`=1: `Ce` is continuously high in RUN and DRAIN; `Dout` advances every clock in RUN; drain lasts exactly `DEPTH` cycles.
- `Dout` changes only on a `Ce`-high edge or a `Load` edge. It is stable throughout every `Ce`-high cycle, so the downstream stage sees a constant input.
- Stop sampled at edge s → the number of `Ce`-high cycles after edge s is exactly `DEPTH`, then `Run` drops. It drops in the cycle after the edge consuming the last strobe.
- `Wrap` coincides with the cycle in which `Dout` shows the wrapped value.

## Structure
- **Package `ce_src_pkg`:**
  - state enum typedef (IDLE, RUN, DRAIN);
  - default constants for `WIDTH`, `DIV`, `DEPTH`.
- **Sub-module `ce_prescaler`:**
  - modulo-`DIV` counter with synchronous clear and enable, registered strobe output;
  - also reusable for other clock-enable generation in the design.
- The FSM, data counter, drain counter and `Wrap` logic live in the top module.

## Test plan
- **Reset mid-RUN:** assert `RST` low mid-RUN with `Dout`=9 → `Dout`, `Ce`, `Run`, `Wrap` read 0 asynchronously, before the next edge; state is IDLE after release.
- **Basic run:** `DIV`=4, `Load` `LdVal`=3 in IDLE, Start, `Up`=1 → `Ce` high on cycles k+5, k+9, k+13 (cycle after edges k+4, k+8, k+12); `Dout` 3→4→5→6 after each strobe.
- **Wrap down:** `DIV`=1, `Load` 1, `Up`=0, run 3 clocks → `Dout` 1,0,15,14; one `Wrap` pulse coincident with 15.
- **Drain:** Stop in RUN with `Dout`=7, `DEPTH`=2 → exactly 2 further `Ce` strobes with `Dout` held at 7, then `Run`=0 and `Ce`=0. The downstream chain output shows 7.
- **Priority:** `Start`+`Stop` together in IDLE → remains IDLE. `Load`=12 on a `Ce`-high edge in RUN → `Dout`=12, no increment.
- **Ignored inputs in DRAIN:** `Load` and `Start` during DRAIN → ignored; `Dout` unchanged; returns to IDLE after `DEPTH` strobes.
